mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO result registers; replaces the single-cycle combinational multiply/divide path in the datapath.
- Radix-2 iterative: one partial product or one quotient bit per clock, so the multiply/divide path no longer sets the cycle time.
- Sits beside the ALU in EX. The pipeline issues with start/op, stalls on busy, and reads hi/lo after done.

Parameters:
- WIDTH, 32, operand width; hi and lo are WIDTH bits each.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request pulse; sampled only in IDLE.
- op, input, 2, 0=MULTU, 1=MULT (signed), 2=DIVU, 3=DIV (signed); sampled with start.
- x, input, WIDTH, multiplicand or dividend; sampled with start.
- y, input, WIDTH, multiplier or divisor; sampled with start.
- busy, output, 1, high while an operation is in flight.
- done, output, 1, one-cycle pulse when hi/lo update.
- hi, output, WIDTH, product upper half or remainder.
- lo, output, WIDTH, product lower half or quotient.
- div_zero, output, 1, registered; set on done of a divide with y==0, cleared on the next accepted start.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, counter=0.
  - busy=0, done=0, hi=0, lo=0, div_zero=0.
  - The in-flight operation is discarded; no done is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 latches op, |x|, |y| and the result sign flags (signed ops only), loads counter=WIDTH, then goes to CALC; busy=1 from the next cycle.
  - start=0: stay in IDLE.
- CALC:
  - One iteration per clock.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract over a WIDTH remainder and WIDTH quotient.
  - The counter decrements each cycle; at counter==1 the state goes to FIX.
- FIX (one cycle):
  - Applies sign correction and writes hi/lo.
  - done<=1 for exactly one cycle, busy<=0, state returns to IDLE.
- Latency: start sampled at edge 0 → done and new hi/lo visible after edge WIDTH+1. A new start is accepted in the same cycle done is high.
- start or op changes while busy are ignored; no queueing.
- hi/lo hold their value between operations and are never partially updated.
- Signed rules:
  - Product sign = x[MSB]^y[MSB].
  - Quotient sign = x[MSB]^y[MSB]; remainder takes the sign of the dividend (truncating division).
  - Two's complement negation of |MIN| is exact in WIDTH+1 internal bits.
- Divide by zero (DIV or DIVU, y==0): lo = all ones, hi = x (unmodified), div_zero=1. Latency is unchanged.
- Signed overflow (DIV, x=MIN, y=-1): lo=MIN, hi=0, div_zero=0.
- MULTU/MULT: {hi,lo} = full 2*WIDTH product; no overflow indication.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: if x==0 or y==0 when start is accepted, IDLE goes directly to FIX.
  - done appears after edge 1.
  - The divide-by-zero result rules still apply.
  - Product of zero gives hi=lo=0; dividend zero with y≠0 gives hi=lo=0.
- Undefined: every operation takes the full WIDTH+1 latency. Results are bit-identical either way.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULTU/MDU_MULT/MDU_DIVU/MDU_DIV;
  - state encoding localparams (IDLE/CALC/FIX);
  - the hex ALU_OP codes that select the MDU path in the decoder.
- Sub-module: mdu_sign_fix (combinational) for operand absolute value and result re-negation. Iteration datapath and FSM stay in mdu_seq.

Test Plan (WIDTH=32):
- MULT x=FFFFFFF9 (-7), y=00000003 → after 33 edges, done pulse; hi=FFFFFFFF, lo=FFFFFFEB; busy low in the same cycle.
- MULTU x=FFFFFFFF, y=FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- DIV x=FFFFFFF9 (-7), y=00000002 → lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). Then DIV x=80000000, y=FFFFFFFF → lo=80000000, hi=00000000.
- DIVU x=00000007, y=00000000 → lo=FFFFFFFF, hi=00000007, div_zero=1. The next start clears div_zero. With MDU_EARLY_OUT_EN, DIVU x=0, y=5 → done after 1 edge, hi=lo=0.
- Start MULTU 5×6, pulse start with different operands at cycle 10 (ignored) → hi=0, lo=0000001E, exactly one done. Back-to-back start on the done cycle is accepted.
- Assert rst asynchronously (mid-clock) at cycle 15 of a DIVU → busy/done/hi/lo/div_zero go to 0 immediately; no done follows; the next op completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, decoder ALU_OP codes.
// Helpers classify an op as signed and/or divide.
package mdu_pkg;

  localparam logic [1:0] MDU_MULTU = 2'd0;
  localparam logic [1:0] MDU_MULT  = 2'd1;
  localparam logic [1:0] MDU_DIVU  = 2'd2;
  localparam logic [1:0] MDU_DIV   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_FIX  = ST_FIX
  } mdu_state_t;

  // Decoder ALU_OP values that steer an instruction to the MDU instead of the ALU.
  localparam logic [5:0] ALU_OP_MULT  = 6'h18;
  localparam logic [5:0] ALU_OP_MULTU = 6'h19;
  localparam logic [5:0] ALU_OP_DIV   = 6'h1A;
  localparam logic [5:0] ALU_OP_DIVU  = 6'h1B;

  // Per-operation context captured at start.
  typedef struct packed {
    logic [1:0] op;
    logic       neg_q;   // negate product / quotient
    logic       neg_r;   // negate remainder
    logic       dz;      // divide by zero
  } mdu_ctx_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitude and result re-negation for signed multiply/divide.
// Latency: combinational. Backpressure: none.
// Negation is done in WIDTH+1 bits so |MIN| is exact.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               sgn,
  output logic [WIDTH-1:0]   abs_x,
  output logic [WIDTH-1:0]   abs_y,
  input  logic               is_mul,
  input  logic               neg_q,
  input  logic               neg_r,
  input  logic [2*WIDTH-1:0] raw,
  output logic [2*WIDTH-1:0] res
);

  logic [WIDTH:0]     x_ext, y_ext, x_neg, y_neg;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg, rem_neg;

  assign x_ext = {sgn & x[WIDTH-1], x};
  assign y_ext = {sgn & y[WIDTH-1], y};
  assign x_neg = -x_ext;
  assign y_neg = -y_ext;
  assign abs_x = x_ext[WIDTH] ? x_neg[WIDTH-1:0] : x;
  assign abs_y = y_ext[WIDTH] ? y_neg[WIDTH-1:0] : y;

  assign prod_neg = -raw;
  assign quo_neg  = -raw[WIDTH-1:0];
  assign rem_neg  = -raw[2*WIDTH-1:WIDTH];

  always_comb begin
    res = raw;
    if (is_mul) begin
      if (neg_q) res = prod_neg;
    end else begin
      if (neg_r) res[2*WIDTH-1:WIDTH] = rem_neg;
      if (neg_q) res[WIDTH-1:0]       = quo_neg;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Radix-2 iterative multiply/divide unit with HI/LO result registers (MDU_EARLY_OUT_EN: zero-operand bypass).
// Latency: WIDTH+1 cycles start-to-done (1 with early-out on a zero operand).
// Backpressure: busy high while in flight; start is ignored unless idle.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;   // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;  // multiplicand or divisor magnitude
  mdu_ctx_t           ctx;

  logic [WIDTH-1:0]   abs_x, abs_y;
  logic [2*WIDTH-1:0] fixed;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .x      (x),
    .y      (y),
    .sgn    (op_is_signed(op)),
    .abs_x  (abs_x),
    .abs_y  (abs_y),
    .is_mul (!op_is_div(ctx.op)),
    .neg_q  (ctx.neg_q),
    .neg_r  (ctx.neg_r),
    .raw    (acc),
    .res    (fixed)
  );

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: borrow out of the WIDTH+1 trial means keep the shifted remainder.
  assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
  assign div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic start_dz;
  assign start_dz = op_is_div(op) && (y == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      ctx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ctx.op    <= op;
            ctx.neg_q <= op_is_signed(op) & (x[WIDTH-1] ^ y[WIDTH-1]);
            ctx.neg_r <= op_is_signed(op) & x[WIDTH-1];
            ctx.dz    <= start_dz;
            acc       <= {{WIDTH{1'b0}}, abs_x};
            opnd      <= abs_y;
            cnt       <= CNT_W'(WIDTH);
            busy      <= 1'b1;
            div_zero  <= 1'b0;
            state     <= S_CALC;
`ifdef MDU_EARLY_OUT_EN
            // Preload exactly what the full iteration would have produced.
            if (x == '0 || y == '0) begin
              acc   <= start_dz ? {abs_x, {WIDTH{1'b1}}} : '0;
              cnt   <= '0;
              state <= S_FIX;
            end
`endif
          end
        end
        S_CALC: begin
          acc <= op_is_div(ctx.op) ? div_next : mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          hi       <= fixed[2*WIDTH-1:WIDTH];
          lo       <= ctx.dz ? {WIDTH{1'b1}} : fixed[WIDTH-1:0];
          div_zero <= ctx.dz;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus randomized ops against an arithmetic model.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] x = '0, y = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: return {32'h0, a} * {32'h0, b};
      2'd1: return 64'(sa * sb);
      2'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Entered and left at a negedge; returns on the cycle done is high so the next call is back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int exp_lat, lat;
    bit seen;
    exp     = model(o, a, b);
    exp_lat = (EARLY && (a == 0 || b == 0)) ? 1 : 33;
    start = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); x = $urandom; y = $urandom;
    @(negedge clk);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("div_zero_cleared", {63'd0, div_zero}, 64'd0);
    lat = 0;
    seen = 1'b0;
    while (lat < 100 && !seen) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("latency", 64'(lat), 64'(exp_lat));
      check("hi", {32'd0, hi}, {32'd0, exp[63:32]});
      check("lo", {32'd0, lo}, {32'd0, exp[31:0]});
      check("div_zero", {63'd0, div_zero}, {63'd0, (o[1] && b == 0)});
      check("busy_at_done", {63'd0, busy}, 64'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    logic [31:0] hold_hi, hold_lo;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_div_zero", {63'd0, div_zero}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(2'd1, 32'hFFFFFFF9, 32'h00000003);
    check("mult_neg7x3", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(2'd3, 32'hFFFFFFF9, 32'h00000002);
    check("div_neg7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'd3, 32'h80000000, 32'hFFFFFFFF);
    check("div_overflow", {hi, lo}, 64'h00000000_80000000);
    run_op(2'd2, 32'h00000007, 32'h00000000);
    check("divu_by_zero", {hi, lo}, 64'h00000007_FFFFFFFF);
    run_op(3'd3, 32'hFFFFFFF0, 32'h00000000);
    run_op(2'd2, 32'h00000000, 32'h00000005);
    run_op(2'd1, 32'h00000000, 32'h12345678);

    // done is one cycle wide and hi/lo hold while idle
    hold_hi = hi;
    hold_lo = lo;
    repeat (3) @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("hold_hilo", {hi, lo}, {hold_hi, hold_lo});

    // Start pulse while busy must be ignored
    start = 1'b1; op = 2'd0; x = 32'd5; y = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 10) begin
        start = 1'b1; op = 2'd2; x = 32'd100; y = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        hold_hi = hi;
        hold_lo = lo;
      end
    end
    start = 1'b0;
    check("ignored_start_dones", 64'(dones), 64'd1);
    check("ignored_start_result", {hold_hi, hold_lo}, 64'h00000000_0000001E);

    // Asynchronous reset mid-divide
    run_op(2'd0, 32'h00010001, 32'h00010001);
    start = 1'b1; op = 2'd2; x = 32'd1000; y = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_div_zero", {63'd0, div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("arst_no_done", 64'(dones), 64'd0);
    run_op(2'd2, 32'd1000, 32'd7);

    // Randomized back-to-back operations
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
